// File: rtl/ms72xx_cfg_pkg.sv
// ms72xx_cfg_pkg: shared types for the MS72xx configuration sequencer and its table ROMs.
// Table entry layout is {op[33:32], addr[31:16], data[15:8], mask[7:0]}.
package ms72xx_cfg_pkg;

    typedef enum logic [1:0] {
        OP_WR   = 2'b00,
        OP_POLL = 2'b01,
        OP_DLY  = 2'b10,
        OP_END  = 2'b11
    } op_e;

    localparam int ENTRY_W = 34;
    localparam int OP_LSB   = 32;
    localparam int ADDR_LSB = 16;
    localparam int DATA_LSB = 8;
    localparam int MASK_LSB = 0;

    // Field order matches the bit positions above, so a raw entry casts straight in.
    typedef struct packed {
        op_e         op;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  mask;
    } entry_t;

    typedef enum logic [3:0] {
        S_RST_LOW,
        S_RST_SETTLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DELAY,
        S_DONE,
        S_ERR
    } state_e;

    function automatic logic [ENTRY_W-1:0] mk_entry(op_e op, logic [15:0] addr,
                                                    logic [7:0] data, logic [7:0] mask);
        return {op, addr, data, mask};
    endfunction

endpackage

// File: rtl/ms72xx_cfg_rom.sv
// ms72xx_cfg_rom: per-chip configuration table, combinational lookup on the table index.
// Ports: tbl_idx (in, IW) entry index; tbl_entry (out, 34) {op, addr, data, mask}.
// CHIP selects the table: 7200 for the receiver, anything else for the MS7210 transmitter.
module ms72xx_cfg_rom
    import ms72xx_cfg_pkg::*;
#(
    parameter int  CHIP        = 7210,
    parameter int  NUM_ENTRIES = 64,
    localparam int IW          = $clog2(NUM_ENTRIES)
) (
    input  logic [IW-1:0]      tbl_idx,
    output logic [ENTRY_W-1:0] tbl_entry
);

    always_comb begin
        tbl_entry = mk_entry(OP_END, 16'h0000, 8'h00, 8'h00);
        if (CHIP == 7200) begin
            case (int'(tbl_idx))
                0:       tbl_entry = mk_entry(OP_WR,   16'h0080, 8'h00, 8'h00);
                1:       tbl_entry = mk_entry(OP_DLY,  16'h0000, 8'h0A, 8'h00);
                2:       tbl_entry = mk_entry(OP_POLL, 16'h0003, 8'h01, 8'h01);
                3:       tbl_entry = mk_entry(OP_WR,   16'h0004, 8'h11, 8'h00);
                default: ;
            endcase
        end else begin
            case (int'(tbl_idx))
                0:       tbl_entry = mk_entry(OP_WR,  16'h0003, 8'h5A, 8'h00);
                1:       tbl_entry = mk_entry(OP_WR,  16'h1281, 8'h04, 8'h00);
                2:       tbl_entry = mk_entry(OP_DLY, 16'h0000, 8'h01, 8'h00);
                3:       tbl_entry = mk_entry(OP_WR,  16'h0016, 8'h04, 8'h00);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ms72xx_cfg_seq.sv
// ms72xx_cfg_seq: pulses the chip hardware reset, then walks a configuration table of
// write / poll-until-match / millisecond-delay ops over the i2c_dri handshake.
// Ports: clk, rst_n (async active-low), start (rerun pulse); tbl_idx/tbl_entry to the
// table ROM; i2c_exec/i2c_rh_wl/i2c_addr/i2c_data_w requests and i2c_data_r/i2c_done/
// i2c_ack (1 = NACK) responses; rstn_out chip reset; init_done/init_err/err_idx status.
module ms72xx_cfg_seq
    import ms72xx_cfg_pkg::*;
#(
    parameter int  NUM_ENTRIES    = 64,
    parameter int  RST_LOW_CYC    = 10000,
    parameter int  RST_SETTLE_CYC = 20000,
    parameter int  MS_CYC         = 1000,
    parameter int  MAX_RETRY      = 3,
    parameter int  POLL_MAX       = 255,
    localparam int IW             = $clog2(NUM_ENTRIES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [IW-1:0]      tbl_idx,
    input  logic [ENTRY_W-1:0] tbl_entry,
    output logic               i2c_exec,
    output logic               i2c_rh_wl,
    output logic [15:0]        i2c_addr,
    output logic [7:0]         i2c_data_w,
    input  logic [7:0]         i2c_data_r,
    input  logic               i2c_done,
    input  logic               i2c_ack,
    output logic               rstn_out,
    output logic               init_done,
    output logic               init_err,
    output logic [IW-1:0]      err_idx
);

    localparam logic [31:0]   LOW_LAST    = RST_LOW_CYC - 1;
    localparam logic [31:0]   SETTLE_LAST = RST_SETTLE_CYC - 1;
    localparam logic [31:0]   MS_LEN      = MS_CYC;
    localparam logic [31:0]   RETRY_LIM   = MAX_RETRY;
    localparam logic [31:0]   POLL_LAST   = POLL_MAX - 1;
    localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_ENTRIES - 1);

    state_e        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d, retry_q, retry_d, poll_q, poll_d;
    logic [IW-1:0] idx_q, idx_d, err_idx_q, err_idx_d;
    entry_t        ent_q, ent_d, ent;
    logic          nack_q, nack_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          last, match;
    logic [31:0]   dly_last;
    state_e        adv_state;
    logic [IW-1:0] adv_idx;

    assign ent = entry_t'(tbl_entry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST_LOW;
            cnt_q     <= '0;
            retry_q   <= '0;
            poll_q    <= '0;
            idx_q     <= '0;
            err_idx_q <= '0;
            ent_q     <= '0;
            nack_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            poll_q    <= poll_d;
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            ent_q     <= ent_d;
            nack_q    <= nack_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        last      = idx_q == IDX_LAST;
        // The last table slot finishes the run even without an END op.
        adv_state = last ? S_DONE : S_FETCH;
        adv_idx   = last ? idx_q : idx_q + 1'b1;
        match     = ((rdata_q ^ ent_q.data) & ent_q.mask) == 8'h00;
        dly_last  = 32'(ent_q.data) * MS_LEN - 32'd1;
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        poll_d    = poll_q;
        idx_d     = idx_q;
        err_idx_d = err_idx_q;
        ent_d     = ent_q;
        nack_d    = nack_q;
        rdata_d   = rdata_q;
        case (state_q)
            S_RST_LOW: begin
                state_d = (cnt_q == LOW_LAST) ? S_RST_SETTLE : S_RST_LOW;
                cnt_d   = (cnt_q == LOW_LAST) ? '0 : cnt_q + 32'd1;
            end
            S_RST_SETTLE: begin
                state_d = (cnt_q == SETTLE_LAST) ? S_FETCH : S_RST_SETTLE;
                cnt_d   = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + 32'd1;
                idx_d   = '0;
            end
            S_FETCH: begin
                // Latching the entry here keeps address/data stable for the whole transfer.
                ent_d = ent;
                case (ent.op)
                    OP_WR, OP_POLL: state_d = S_ISSUE;
                    OP_DLY: begin
                        state_d = (ent.data == 8'h00) ? adv_state : S_DELAY;
                        idx_d   = (ent.data == 8'h00) ? adv_idx : idx_q;
                        cnt_d   = '0;
                    end
                    default: state_d = S_DONE;
                endcase
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (i2c_done) begin
                    state_d = S_CHECK;
                    nack_d  = i2c_ack;
                    rdata_d = i2c_data_r;
                end
            end
            S_CHECK: begin
                if (nack_q) begin
                    state_d   = (retry_q < RETRY_LIM) ? S_ISSUE : S_ERR;
                    retry_d   = (retry_q < RETRY_LIM) ? retry_q + 32'd1 : retry_q;
                    err_idx_d = idx_q;
                end else if (ent_q.op == OP_WR || match) begin
                    retry_d = '0;
                    poll_d  = '0;
                    state_d = adv_state;
                    idx_d   = adv_idx;
                end else begin
                    // An ACKed read still restarts the NACK budget.
                    retry_d   = '0;
                    state_d   = (poll_q < POLL_LAST) ? S_ISSUE : S_ERR;
                    poll_d    = (poll_q < POLL_LAST) ? poll_q + 32'd1 : poll_q;
                    err_idx_d = idx_q;
                end
            end
            S_DELAY: begin
                state_d = (cnt_q == dly_last) ? adv_state : S_DELAY;
                idx_d   = (cnt_q == dly_last) ? adv_idx : idx_q;
                cnt_d   = (cnt_q == dly_last) ? '0 : cnt_q + 32'd1;
            end
            default: ;
        endcase
        // A restart pre-empts everything, including a transfer still in flight;
        // its late i2c_done lands in RST_LOW and is never looked at.
        if (start) begin
            state_d   = S_RST_LOW;
            cnt_d     = '0;
            retry_d   = '0;
            poll_d    = '0;
            idx_d     = '0;
            err_idx_d = '0;
            nack_d    = 1'b0;
        end
    end

    always_comb begin
        rstn_out   = state_q != S_RST_LOW;
        i2c_exec   = state_q == S_ISSUE;
        i2c_rh_wl  = ent_q.op == OP_POLL;
        i2c_addr   = ent_q.addr;
        i2c_data_w = ent_q.data;
        init_done  = state_q == S_DONE;
        init_err   = state_q == S_ERR;
        tbl_idx    = idx_q;
        err_idx    = err_idx_q;
    end

endmodule

// File: tb/tb_ms72xx_cfg_seq.sv
// tb_ms72xx_cfg_seq: scoreboard bench for the MS72xx configuration sequencer.
module tb_ms72xx_cfg_seq;
    import ms72xx_cfg_pkg::*;

    localparam int NE = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic        rh;
        logic [15:0] a;
        logic [7:0]  d;
    } xfer_t;

    typedef struct packed {
        logic       nack;
        logic [7:0] rd;
    } resp_t;

    logic               clk = 1'b0;
    logic               rst_n, start, use_rom;
    logic [IW-1:0]      tbl_idx, err_idx;
    logic [ENTRY_W-1:0] tbl_entry, rom_entry;
    logic [ENTRY_W-1:0] tbl [NE];
    logic               i2c_exec, i2c_rh_wl, i2c_done, i2c_ack;
    logic [15:0]        i2c_addr;
    logic [7:0]         i2c_data_w, i2c_data_r;
    logic               rstn_out, init_done, init_err;

    xfer_t exp_q[$];
    resp_t resp_q[$];
    int    exec_cyc[$];
    int    n_chk = 0, n_pass = 0, n_unexp = 0, n_both = 0;
    int    cyc = 0, lat = 2, done_cyc = 0, done_rise = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign tbl_entry = use_rom ? rom_entry : tbl[tbl_idx];

    ms72xx_cfg_seq #(
        .NUM_ENTRIES(NE), .RST_LOW_CYC(4), .RST_SETTLE_CYC(4),
        .MS_CYC(10), .MAX_RETRY(3), .POLL_MAX(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .tbl_idx(tbl_idx), .tbl_entry(tbl_entry),
        .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl), .i2c_addr(i2c_addr),
        .i2c_data_w(i2c_data_w), .i2c_data_r(i2c_data_r), .i2c_done(i2c_done),
        .i2c_ack(i2c_ack), .rstn_out(rstn_out), .init_done(init_done),
        .init_err(init_err), .err_idx(err_idx)
    );

    ms72xx_cfg_rom #(.CHIP(7210), .NUM_ENTRIES(NE)) u_rom (
        .tbl_idx(tbl_idx), .tbl_entry(rom_entry)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void push_x(input logic rh, input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back('{rh: rh, a: a, d: d});
    endfunction

    function automatic void push_r(input logic nack, input logic [7:0] rd);
        resp_q.push_back('{nack: nack, rd: rd});
    endfunction

    task automatic clr_tbl();
        for (int i = 0; i < NE; i++) tbl[i] = mk_entry(OP_END, 16'h0, 8'h0, 8'h0);
    endtask

    task automatic restart();
        @(posedge clk);
        #1 start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic finish_test(input string t, input logic exp_done, input int eidx);
        int n = 0;
        while (!(init_done || init_err) && n < 2000) begin
            tick(1);
            n++;
        end
        chk({t, "_in_budget"}, 32'(n < 2000), 32'd1);
        tick(40);
        chk({t, "_init_done"}, 32'(init_done), 32'(exp_done));
        chk({t, "_init_err"}, 32'(init_err), 32'(!exp_done));
        if (!exp_done) chk({t, "_err_idx"}, 32'(err_idx), 32'(eidx));
        chk({t, "_sb_left"}, 32'(exp_q.size()), 32'd0);
        chk({t, "_extra_exec"}, 32'(n_unexp), 32'd0);
        exp_q.delete();
        resp_q.delete();
        n_unexp = 0;
    endtask

    // I2C slave: checks each request against the scoreboard, answers after lat cycles.
    initial begin
        xfer_t e;
        resp_t r;
        logic  have_e;
        i2c_done = 1'b0;
        i2c_ack = 1'b0;
        i2c_data_r = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (i2c_exec) begin
                exec_cyc.push_back(cyc);
                have_e = exp_q.size() != 0;
                if (have_e) begin
                    e = exp_q.pop_front();
                    chk("rh_wl", 32'(i2c_rh_wl), 32'(e.rh));
                    chk("addr", 32'(i2c_addr), 32'(e.a));
                    if (!e.rh) chk("data_w", 32'(i2c_data_w), 32'(e.d));
                end else begin
                    n_unexp++;
                end
                if (resp_q.size() != 0) r = resp_q.pop_front();
                else r = '{nack: 1'b0, rd: 8'hFF};
                tick(lat);
                if (have_e) chk("addr_hold", 32'(i2c_addr), 32'(e.a));
                i2c_done = 1'b1;
                i2c_ack = r.nack;
                i2c_data_r = r.rd;
                done_cyc = cyc + 1;
                tick(1);
                i2c_done = 1'b0;
                i2c_ack = 1'b0;
                i2c_data_r = 8'h00;
            end
        end
    end

    initial begin
        logic pd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (init_done && !pd) done_rise = cyc;
            pd = init_done;
            if (init_done && init_err) n_both++;
        end
    end

    initial begin
        int rel, rise, n;
        rst_n = 1'b1;
        start = 1'b0;
        use_rom = 1'b0;
        clr_tbl();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rstn_out", 32'(rstn_out), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_init_err", 32'(init_err), 32'd0);
        chk("rst_exec", 32'(i2c_exec), 32'd0);
        chk("rst_tbl_idx", 32'(tbl_idx), 32'd0);
        chk("rst_err_idx", 32'(err_idx), 32'd0);
        chk("rst_addr", 32'(i2c_addr), 32'd0);
        chk("rst_data_w", 32'(i2c_data_w), 32'd0);
        chk("rst_rh_wl", 32'(i2c_rh_wl), 32'd0);

        // Single write then END, straight out of reset.
        tbl[0] = mk_entry(OP_WR, 16'h0003, 8'h5A, 8'h00);
        push_x(1'b0, 16'h0003, 8'h5A);
        tick(3);
        rst_n = 1'b1;
        rel = cyc;
        n = 0;
        while (!rstn_out && n < 100) begin tick(1); n++; end
        rise = cyc;
        chk("rst_low_cycles", 32'(rise - rel), 32'd4);
        n = 0;
        while (exec_cyc.size() == 0 && n < 100) begin tick(1); n++; end
        // Four settle cycles plus the FETCH cycle precede the request.
        chk("settle_to_exec", 32'(exec_cyc[0] - rise), 32'd5);
        finish_test("t1", 1'b1, 0);
        chk("done_latency", 32'(done_rise - done_cyc), 32'd2);

        // NACK streak on entry 1 exhausts the retries.
        clr_tbl();
        tbl[0] = mk_entry(OP_WR, 16'h0100, 8'h11, 8'h00);
        tbl[1] = mk_entry(OP_WR, 16'h0101, 8'h22, 8'h00);
        tbl[2] = mk_entry(OP_WR, 16'h0102, 8'h33, 8'h00);
        push_x(1'b0, 16'h0100, 8'h11);
        push_r(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            push_x(1'b0, 16'h0101, 8'h22);
            push_r(1'b1, 8'h00);
        end
        restart();
        finish_test("t2", 1'b0, 1);

        // Two NACKs recover; a later streak gets a fresh retry budget.
        push_x(1'b0, 16'h0100, 8'h11); push_r(1'b1, 8'h00);
        push_x(1'b0, 16'h0100, 8'h11); push_r(1'b1, 8'h00);
        push_x(1'b0, 16'h0100, 8'h11); push_r(1'b0, 8'h00);
        push_x(1'b0, 16'h0101, 8'h22); push_r(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            push_x(1'b0, 16'h0102, 8'h33);
            push_r(i == 3 ? 1'b0 : 1'b1, 8'h00);
        end
        restart();
        finish_test("t3", 1'b1, 0);

        // Poll until bit 7 is set.
        clr_tbl();
        tbl[0] = mk_entry(OP_POLL, 16'h0010, 8'h80, 8'h80);
        for (int i = 0; i < 3; i++) push_x(1'b1, 16'h0010, 8'h00);
        push_r(1'b0, 8'h00);
        push_r(1'b0, 8'h00);
        push_r(1'b0, 8'h81);
        restart();
        finish_test("t4", 1'b1, 0);

        // Poll that never matches gives up after four reads.
        for (int i = 0; i < 4; i++) begin
            push_x(1'b1, 16'h0010, 8'h00);
            push_r(1'b0, 8'h00);
        end
        restart();
        finish_test("t5", 1'b0, 0);

        // Delays: 3 ms of 10 cycles, then a zero-length delay.
        clr_tbl();
        tbl[0] = mk_entry(OP_WR, 16'h0200, 8'h01, 8'h00);
        tbl[1] = mk_entry(OP_DLY, 16'h0000, 8'h03, 8'h00);
        tbl[2] = mk_entry(OP_WR, 16'h0201, 8'h02, 8'h00);
        tbl[3] = mk_entry(OP_DLY, 16'h0000, 8'h00, 8'h00);
        tbl[4] = mk_entry(OP_WR, 16'h0202, 8'h03, 8'h00);
        push_x(1'b0, 16'h0200, 8'h01);
        push_x(1'b0, 16'h0201, 8'h02);
        push_x(1'b0, 16'h0202, 8'h03);
        exec_cyc.delete();
        restart();
        finish_test("t6", 1'b1, 0);
        // Back-to-back writes are 5 cycles apart; a delay entry adds FETCH plus data*10.
        chk("dly3_gap", 32'(exec_cyc[1] - exec_cyc[0]), 32'd36);
        chk("dly0_gap", 32'(exec_cyc[2] - exec_cyc[1]), 32'd6);

        // Restart while a transfer is outstanding.
        clr_tbl();
        tbl[0] = mk_entry(OP_WR, 16'h0300, 8'hAA, 8'h00);
        tbl[1] = mk_entry(OP_WR, 16'h0301, 8'hBB, 8'h00);
        lat = 6;
        push_x(1'b0, 16'h0300, 8'hAA);
        restart();
        n = 0;
        while (!i2c_exec && n < 200) begin tick(1); n++; end
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("start_rstn_low", 32'(rstn_out), 32'd0);
        chk("start_tbl_idx", 32'(tbl_idx), 32'd0);
        push_x(1'b0, 16'h0300, 8'hAA);
        push_x(1'b0, 16'h0301, 8'hBB);
        finish_test("t7", 1'b1, 0);
        lat = 2;

        // Full table without END stops after the last slot.
        clr_tbl();
        for (int i = 0; i < NE; i++) begin
            tbl[i] = mk_entry(OP_WR, 16'h0400 + 16'(i), 8'(i + 1), 8'h00);
            push_x(1'b0, 16'h0400 + 16'(i), 8'(i + 1));
        end
        restart();
        finish_test("t8", 1'b1, 0);
        chk("t8_last_idx", 32'(tbl_idx), 32'(NE - 1));

        // Real MS7210 table from the ROM.
        use_rom = 1'b1;
        push_x(1'b0, 16'h0003, 8'h5A);
        push_x(1'b0, 16'h1281, 8'h04);
        push_x(1'b0, 16'h0016, 8'h04);
        restart();
        finish_test("t9", 1'b1, 0);
        use_rom = 1'b0;

        chk("done_err_exclusive", 32'(n_both), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ms72xx_cfg_seq.md
Name: ms72xx_cfg_seq

Overview:
Table-driven I2C configuration sequencer for the MS72xx HDMI receiver/transmitter family. It is the parametrised successor of the fixed write-only MS7210 init controller. It generates the chip hardware-reset pulse, then walks a configuration table supporting write, poll-read-until-match and millisecond delay ops, with NACK retry and error reporting. It sits between a per-chip table ROM and the shared i2c_dri handshake, clocked by i2c_dri's dri_clk.

Parameters:
NUM_ENTRIES, 64, table depth; idx width IW = clog2(NUM_ENTRIES)
RST_LOW_CYC, 10000, cycles rstn_out held low after reset/start
RST_SETTLE_CYC, 20000, cycles after rstn_out rises before first access
MS_CYC, 1000, clk cycles per delay-op millisecond (1 MHz dri_clk)
MAX_RETRY, 3, re-issues of a NACKed transfer before error
POLL_MAX, 255, max reads per poll op before error

Ports:
clk  in  1  sequencer clock (i2c_dri dri_clk)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: rerun full sequence from the reset pulse
tbl_idx  out  IW  table read index
tbl_entry  in  34  {op[33:32], addr[31:16], data[15:8], mask[7:0]}; combinational ROM, valid same cycle
i2c_exec  out  1  one-cycle transfer request
i2c_rh_wl  out  1  1 = read, 0 = write
i2c_addr  out  16  register address
i2c_data_w  out  8  write data
i2c_data_r  in  8  read data, valid with i2c_done
i2c_done  in  1  one-cycle transfer complete
i2c_ack  in  1  1 = slave NACKed during the transfer (sampled with i2c_done)
rstn_out  out  1  chip hardware reset, active low
init_done  out  1  sequence finished OK (level)
init_err  out  1  sequence aborted (level)
err_idx  out  IW  table index of the failing entry

Behaviour:
- Reset values: rstn_out=0, init_done=0, init_err=0, err_idx=0, tbl_idx=0, i2c_exec=0, i2c_rh_wl=0, i2c_addr=0, i2c_data_w=0; state RST_LOW, counters 0.
- Ops: 00 WRITE addr<-data. 01 POLL: read addr until (rd & mask)==(data & mask). 10 DELAY: data ms (0 = no wait, advance next cycle). 11 END.
- States:
  - RST_LOW: rstn_out=0 for RST_LOW_CYC cycles -> RST_SETTLE.
  - RST_SETTLE: rstn_out=1, wait RST_SETTLE_CYC cycles -> FETCH, tbl_idx=0.
  - FETCH: decode tbl_entry. WRITE/POLL -> ISSUE. DELAY -> DELAY. END -> DONE.
  - ISSUE: pulse i2c_exec exactly one cycle; addr/data/rh_wl registered the same cycle and held stable until i2c_done -> WAIT.
  - WAIT: on i2c_done -> CHECK. Never reissues while waiting.
  - CHECK on NACK: retry_cnt<MAX_RETRY -> retry_cnt++, ISSUE. Otherwise -> ERR.
  - CHECK on ACK, WRITE or POLL-match: retry_cnt=0, poll_cnt=0, tbl_idx++, FETCH.
  - CHECK on ACK, POLL-mismatch: poll_cnt<POLL_MAX-1 -> poll_cnt++, ISSUE. Otherwise -> ERR.
  - DELAY: count data*MS_CYC cycles -> tbl_idx++, FETCH.
  - DONE: init_done=1, hold.
  - ERR: init_err=1, err_idx=tbl_idx, hold.
- Total issues for one entry ≤ MAX_RETRY+1 per NACK streak; retry_cnt resets on any ACK.
- tbl_idx reaching NUM_ENTRIES-1 without END: that entry is executed, then -> DONE (no wrap).
- Transfer latency: i2c_exec one cycle after FETCH; next FETCH one cycle after CHECK.
- start (any state, including mid-transfer): -> RST_LOW, clear init_done/init_err/counters/tbl_idx. A pending i2c_done after start is ignored. start and rst_n deassertion in the same cycle: start wins.
- init_done and init_err are never both 1.

Decomposition:
- Package ms72xx_cfg_pkg: op encodings (OP_WR, OP_POLL, OP_DLY, OP_END), entry field bit positions, state encoding.
- Sub-module ms72xx_cfg_rom: per-chip table (MS7200/MS7210 variants via parameter), combinational case on tbl_idx. The sequencer itself holds no table data.

Test Plan:
- Reset release, table {WR 0x0003<-0x5A, END}, RST_LOW_CYC=4, RST_SETTLE_CYC=4 -> rstn_out low 4 cycles, first i2c_exec after 4 more, addr=0x0003, data_w=0x5A, rh_wl=0; init_done=1 two cycles after i2c_done.
- NACK model on entry 1, MAX_RETRY=3 -> exactly 4 exec pulses for entry 1, then init_err=1, err_idx=1, no further exec.
- NACK on the first 2 attempts then ACK -> 3 exec pulses, sequence continues; later NACK streak gets a fresh 3 retries.
- POLL addr 0x0010 mask 0x80 data 0x80, read returns 0x00,0x00,0x81 -> 3 reads then advance; with POLL_MAX=4 and 0x00 always -> 4 reads, then init_err.
- DELAY data=3, MS_CYC=10 -> next exec appears ≥30 cycles after DELAY entry; DELAY data=0 -> advances with no wait.
- start pulse asserted while in WAIT -> rstn_out=0 the next cycle, late i2c_done ignored, full sequence reruns from idx 0 and reaches init_done.
